// File: rtl/bkt_lvl_finder.sv
// Backtrack-level finder: drives the conflict level into the level-state chain, OR-reduces the
// per-level results, and pulses apply_bkt to mark the selected level as backtracked.
module bkt_lvl_finder #(
   parameter int unsigned NUM_LVLS     = 32,
   parameter int unsigned WIDTH_LVL    = 16,
   parameter int unsigned WIDTH_BIN_ID = 10,
   parameter int unsigned WIDTH_CNT    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start_i,
   input  logic [WIDTH_LVL-1:0]             max_lvl_i,
   input  logic                             flush_i,
   output logic                             ready_o,
   output logic [WIDTH_LVL-1:0]             max_lvl_o,
   output logic [1:0]                       findflag_o,
   output logic                             apply_bkt_o,
   input  logic [NUM_LVLS*WIDTH_BIN_ID-1:0] bkt_bin_vec_i,
   input  logic [NUM_LVLS*WIDTH_LVL-1:0]    bkt_lvl_vec_i,
   output logic                             done_o,
   output logic                             found_o,
   output logic [WIDTH_BIN_ID-1:0]          bkt_bin_o,
   output logic [WIDTH_LVL-1:0]             bkt_lvl_o,
   output logic                             multi_err_o,
   output logic [WIDTH_CNT-1:0]             bkt_cnt_o
);

   typedef enum logic [2:0] {StIdle, StSearch, StCapture, StApply, StDone} state_e;

   state_e                  state_q, state_d;
   logic [WIDTH_LVL-1:0]    max_q, max_d;
   logic                    found_q, found_d;
   logic [WIDTH_BIN_ID-1:0] bin_q, bin_d;
   logic [WIDTH_LVL-1:0]    lvl_q, lvl_d;
   logic                    multi_q, multi_d;
   logic [WIDTH_CNT-1:0]    cnt_q, cnt_d;

   logic [WIDTH_BIN_ID-1:0] red_bin;
   logic [WIDTH_LVL-1:0]    red_lvl;
   logic                    nz_seen, nz_multi;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         max_q   <= '0;
         found_q <= 1'b0;
         bin_q   <= '0;
         lvl_q   <= '0;
         multi_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         max_q   <= max_d;
         found_q <= found_d;
         bin_q   <= bin_d;
         lvl_q   <= lvl_d;
         multi_q <= multi_d;
         cnt_q   <= cnt_d;
      end
   end

   // Only the selected instance drives nonzero slices, so OR-reduce recovers its values.
   always_comb begin
      red_bin  = '0;
      red_lvl  = '0;
      nz_seen  = 1'b0;
      nz_multi = 1'b0;
      for (int unsigned i = 0; i < NUM_LVLS; i++) begin
         red_bin = red_bin | bkt_bin_vec_i[i*WIDTH_BIN_ID +: WIDTH_BIN_ID];
         red_lvl = red_lvl | bkt_lvl_vec_i[i*WIDTH_LVL +: WIDTH_LVL];
         if (bkt_lvl_vec_i[i*WIDTH_LVL +: WIDTH_LVL] != '0) begin
            if (nz_seen) nz_multi = 1'b1;
            nz_seen = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:    if (start_i) state_d = StSearch;
            StSearch:  state_d = StCapture;
            StCapture: state_d = (red_lvl != '0) ? StApply : StDone;
            StApply:   state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      max_d   = max_q;
      found_d = found_q;
      bin_d   = bin_q;
      lvl_d   = lvl_q;
      multi_d = multi_q;
      cnt_d   = cnt_q;
      if (!flush_i) begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  max_d   = max_lvl_i;
                  found_d = 1'b0;
                  bin_d   = '0;
                  lvl_d   = '0;
               end
            end
            StCapture: begin
               bin_d   = red_bin;
               lvl_d   = red_lvl;
               found_d = (red_lvl != '0);
               if (nz_multi) multi_d = 1'b1;
            end
            StApply: begin
               if (cnt_q != {WIDTH_CNT{1'b1}}) cnt_d = cnt_q + WIDTH_CNT'(1);
            end
            default: ;
         endcase
      end
   end

   // max_lvl_o stays valid through APPLY so the chain selection does not move under the pulse.
   always_comb begin
      ready_o     = (state_q == StIdle);
      findflag_o  = 2'b00;
      apply_bkt_o = (state_q == StApply) && !flush_i;
      done_o      = (state_q == StDone) && !flush_i;
      max_lvl_o   = '0;
      if (!flush_i && (state_q == StSearch || state_q == StCapture || state_q == StApply)) begin
         max_lvl_o = max_q;
      end
      found_o     = found_q;
      bkt_bin_o   = bin_q;
      bkt_lvl_o   = lvl_q;
      multi_err_o = multi_q;
      bkt_cnt_o   = cnt_q;
   end

endmodule
